// File: rtl/fetch_sequencer.sv
// RV32IC fetch sequencer: word fetches from a 1-cycle imem, halfword queue,
// 16/32-bit instruction re-assembly and redirect/halt handling.
module fetch_sequencer #(
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000,
  parameter int          DEPTH_HW  = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        halt_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic        instr_compressed_o,
  output logic [31:0] instr_pc_o
);
  localparam int PW = $clog2(DEPTH_HW);
  localparam int CW = $clog2(DEPTH_HW + 1);

  typedef enum logic {RUN, HALT} state_t;

  state_t                     state_q, state_n;
  logic [DEPTH_HW-1:0][15:0]  q_q;
  logic [PW-1:0]              head_q, tail_q;
  logic [CW-1:0]              occ_q;
  logic [31:0]                fetch_addr_q, head_pc_q;
  logic                       drop_low_q, inflight_q;

  logic [15:0] head_hw, head_hw1;
  logic        is_comp, have_instr, xfer, room;
  logic [1:0]  pop_cnt, push_cnt;
  logic        unused_pc0;

  assign unused_pc0 = redirect_pc_i[0];

  // Pointer advance modulo DEPTH_HW (depth need not be a power of two).
  function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input logic [1:0] n);
    int s;
    s = int'(p) + int'(n);
    if (s >= DEPTH_HW) s = s - DEPTH_HW;
    return PW'(s);
  endfunction

  always_comb begin
    head_hw    = q_q[head_q];
    head_hw1   = q_q[ptr_add(head_q, 2'd1)];
    is_comp    = head_hw[1:0] != 2'b11;
    have_instr = is_comp ? (occ_q >= CW'(1)) : (occ_q >= CW'(2));
    xfer       = instr_valid_o & instr_ready_i;
    pop_cnt    = !xfer ? 2'd0 : (is_comp ? 2'd1 : 2'd2);
    push_cnt   = !inflight_q ? 2'd0 : (drop_low_q ? 2'd1 : 2'd2);
    room       = (32'(occ_q) + (inflight_q ? 32'd2 : 32'd0) + 32'd2) <= 32'(DEPTH_HW);
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      RUN:     if (halt_i)  state_n = HALT;
      HALT:    if (!halt_i) state_n = RUN;
      default: state_n = RUN;
    endcase
  end

  // Gate on the state being entered so halt takes effect, and releases, in the same cycle.
  always_comb begin
    imem_req_o         = !rst_i & !redirect_i & (state_n == RUN) & room;
    imem_addr_o        = fetch_addr_q;
    instr_pc_o         = head_pc_q;
    instr_valid_o      = !rst_i & !redirect_i & have_instr;
    instr_compressed_o = 1'b0;
    instr_o            = 32'h0;
    if (!rst_i) begin
      instr_compressed_o = is_comp;
      instr_o            = is_comp ? {16'h0, head_hw} : {head_hw1, head_hw};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= RUN;
      head_q       <= '0;
      tail_q       <= '0;
      occ_q        <= '0;
      inflight_q   <= 1'b0;
      fetch_addr_q <= {BOOT_ADDR[31:2], 2'b00};
      drop_low_q   <= BOOT_ADDR[1];
      head_pc_q    <= {BOOT_ADDR[31:1], 1'b0};
    end else begin
      state_q <= state_n;
      if (redirect_i) begin
        head_q       <= '0;
        tail_q       <= '0;
        occ_q        <= '0;
        inflight_q   <= 1'b0;
        fetch_addr_q <= {redirect_pc_i[31:2], 2'b00};
        drop_low_q   <= redirect_pc_i[1];
        head_pc_q    <= {redirect_pc_i[31:1], 1'b0};
      end else begin
        inflight_q <= imem_req_o;
        if (imem_req_o) fetch_addr_q <= fetch_addr_q + 32'd4;
        if (inflight_q && drop_low_q) drop_low_q <= 1'b0;
        tail_q <= ptr_add(tail_q, push_cnt);
        occ_q  <= occ_q + CW'(push_cnt) - CW'(pop_cnt);
        if (xfer) begin
          head_q    <= ptr_add(head_q, pop_cnt);
          head_pc_q <= head_pc_q + (is_comp ? 32'd2 : 32'd4);
        end
      end
    end
  end

  // Queue storage needs no reset; occupancy alone decides what is live.
  always_ff @(posedge clk_i) begin
    if (!rst_i && !redirect_i && inflight_q) begin
      if (drop_low_q) begin
        q_q[tail_q] <= imem_rdata_i[31:16];
      end else begin
        q_q[tail_q]                 <= imem_rdata_i[15:0];
        q_q[ptr_add(tail_q, 2'd1)]  <= imem_rdata_i[31:16];
      end
    end
  end
endmodule
